// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vend_pkg
// Purpose : Definitions shared between the coin acceptor and the vending FSM:
//           coin code constants, the coin acceptor measurement-state encoding
//           and a helper that maps a buffered coin kind bit onto a coin code.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEAS     = 2'd1,
    ST_CHECK    = 2'd2,
    ST_REJ_WAIT = 2'd3
  } meas_state_t;

  // Buffered coins are stored as one bit: 0 = Rs.5, 1 = Rs.10.
  function automatic logic [1:0] kind_to_code(input logic kind);
    return kind ? COIN_10 : COIN_5;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
// Module  : coin_debounce
// Purpose : Two-flop synchroniser followed by a debouncer for one coin sensor.
//           The debounced level only follows the synchronised input after it
//           has differed from the current level for DEB_CYCLES consecutive
//           samples, so short glitches never reach the measurement logic.
// Ports   : clk   in  system clock
//           rst   in  asynchronous active-low reset
//           raw   in  asynchronous sensor line
//           level out debounced sensor level
// Rev     : 1.0  initial release
// ============================================================================
module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample that agrees with the current level restarts the run.
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module  : coin_acceptor
// Purpose : Vending machine coin front end. Debounces both coin sensors,
//           measures each coin pulse, rejects short / jammed / double-sensor
//           coins, buffers accepted coins and issues them to the vending FSM
//           as one-cycle coin codes separated by GAP_CYCLES idle cycles.
// Ports   : clk         in   system clock
//           rst         in   asynchronous active-low reset
//           coin5_raw   in   Rs.5 sensor (async)
//           coin10_raw  in   Rs.10 sensor (async)
//           accept_en   in   vending FSM may take a coin this cycle
//           coin_code   out  00 none, 01 Rs.5, 10 Rs.10 (registered)
//           reject      out  one-cycle coin-returned pulse (registered)
//           fifo_full   out  buffer holds FIFO_DEPTH coins
//           coin_count  out  coins currently buffered
// Rev     : 1.0  initial release
// ============================================================================
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_PULSE  = 8,
  parameter int MAX_PULSE  = 64,
  parameter int FIFO_DEPTH = 4,   // power of two, at least 2
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  input  logic                          accept_en,
  output logic [1:0]                    coin_code,
  output logic                          reject,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   coin_count
);

  localparam int CNT_W = $clog2(MAX_PULSE) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  logic s5;
  logic s10;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb5 (
    .clk   (clk),
    .rst   (rst),
    .raw   (coin5_raw),
    .level (s5)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb10 (
    .clk   (clk),
    .rst   (rst),
    .raw   (coin10_raw),
    .level (s10)
  );

  meas_state_t       state;
  logic              kind;        // 0 = Rs.5, 1 = Rs.10
  logic [CNT_W-1:0]  pulse_cnt;

  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [GAP_W-1:0]      gap_cnt;

  logic pop;
  logic push;
  logic my_sensor;
  logic other_sensor;

  assign my_sensor    = kind ? s10 : s5;
  assign other_sensor = kind ? s5  : s10;

  assign pop  = accept_en && (count != '0) && (gap_cnt == '0);
  // A full buffer still takes the coin if an entry leaves in the same cycle.
  assign push = (state == ST_CHECK) && (pulse_cnt >= CNT_W'(MIN_PULSE)) &&
                ((count != (PTR_W+1)'(FIFO_DEPTH)) || pop);

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign coin_count = count;

  // Measurement FSM with registered reject output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      kind      <= 1'b0;
      pulse_cnt <= '0;
      reject    <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s5 && s10) begin
            state  <= ST_REJ_WAIT;
            reject <= 1'b1;
          end else if (s5 || s10) begin
            state     <= ST_MEAS;
            kind      <= s10;
            pulse_cnt <= CNT_W'(1);
          end
        end
        ST_MEAS: begin
          if (other_sensor) begin
            state  <= ST_REJ_WAIT;
            reject <= 1'b1;
          end else if (my_sensor) begin
            if (pulse_cnt >= CNT_W'(MAX_PULSE - 1)) begin
              // Jammed coin: counter parks at MAX_PULSE, never wraps.
              pulse_cnt <= CNT_W'(MAX_PULSE);
              state     <= ST_REJ_WAIT;
              reject    <= 1'b1;
            end else begin
              pulse_cnt <= pulse_cnt + 1'b1;
            end
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          reject <= !push;
          state  <= ST_IDLE;
        end
        ST_REJ_WAIT: begin
          if (!s5 && !s10) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Coin buffer and issue path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      coin_code <= COIN_NONE;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= kind;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        coin_code <= kind_to_code(fifo_mem[rd_ptr]);
        gap_cnt   <= GAP_W'(GAP_CYCLES);
      end else begin
        coin_code <= COIN_NONE;
        if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module  : tb_coin_acceptor
// Purpose : Self-checking bench for coin_acceptor. Coins are described as
//           whole events (sensor, pulse width); a queue-based model decides
//           from the coin rules whether each event is ignored, rejected,
//           buffered or issued, and a monitor records what the DUT emits.
// Rev     : 1.0  initial release
// ============================================================================
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int MINP  = 8;
  localparam int MAXP  = 64;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       accept_en = 1'b0;
  logic [1:0] coin_code;
  logic       reject;
  logic       fifo_full;
  logic [2:0] coin_count;

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEB_CYCLES (DEB),
    .MIN_PULSE  (MINP),
    .MAX_PULSE  (MAXP),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .accept_en  (accept_en),
    .coin_code  (coin_code),
    .reject     (reject),
    .fifo_full  (fifo_full),
    .coin_count (coin_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         rej_seen = 0;
  logic [1:0] obs_codes[$];
  int         obs_cyc[$];
  logic       prev_ae = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (reject) rej_seen++;
      if (coin_code != 2'b00) begin
        check("code_valid", (coin_code == 2'b01) || (coin_code == 2'b10), 1);
        check("issue_while_held", prev_ae, 1);
        if (obs_cyc.size() > 0) check("gap_min", (cyc - obs_cyc[$]) >= GAP + 1, 1);
        obs_codes.push_back(coin_code);
        obs_cyc.push_back(cyc);
      end
    end
    prev_ae = accept_en;
  end

  // ---------------- reference model ----------------
  logic [1:0] model_buf[$];   // coins held while accept_en is low
  logic [1:0] exp_codes[$];   // codes expected on coin_code, in order
  int         exp_rej = 0;
  int         cmp_idx = 0;
  bit         ae_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = Rs.5 sensor, 1 = Rs.10 sensor, 2 = both sensors together
  task automatic coin_event(input int kind, input int width);
    logic [1:0] code;
    coin5_raw  = (kind != 1);
    coin10_raw = (kind != 0);
    repeat (width) tick();
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    repeat (16) tick();
    if (width < DEB) begin
      // too short to survive debouncing: no coin, no reject
    end else if (kind == 2 || width < MINP || width >= MAXP) begin
      exp_rej++;
    end else begin
      code = (kind == 0) ? 2'b01 : 2'b10;
      if (ae_mode) exp_codes.push_back(code);
      else if (model_buf.size() == DEPTH) exp_rej++;
      else model_buf.push_back(code);
    end
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_rej"}, rej_seen, exp_rej);
    check({tag, "_ncodes"}, obs_codes.size(), exp_codes.size());
    while (cmp_idx < obs_codes.size() && cmp_idx < exp_codes.size()) begin
      check({tag, "_code"}, obs_codes[cmp_idx], exp_codes[cmp_idx]);
      cmp_idx++;
    end
    check({tag, "_count"}, coin_count, model_buf.size());
    check({tag, "_full"}, fifo_full, model_buf.size() == DEPTH);
  endtask

  task automatic drain(input bit random_ae);
    int budget;
    while (model_buf.size() > 0) exp_codes.push_back(model_buf.pop_front());
    budget = 400;
    while (obs_codes.size() < exp_codes.size() && budget > 0) begin
      accept_en = random_ae ? ($urandom_range(0, 9) < 7) : 1'b1;
      tick();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 0, 1);
    accept_en = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int kind;
    int r;
    int w;

    // reset state
    repeat (3) tick();
    check("rst_code", coin_code, 0);
    check("rst_reject", reject, 0);
    check("rst_full", fifo_full, 0);
    check("rst_count", coin_count, 0);
    rst = 1'b1;
    repeat (2) tick();

    ae_mode = 1'b1;
    accept_en = 1'b1;
    coin_event(0, 20);  checkpoint("t1_rs5");
    coin_event(1, 5);   checkpoint("t2_short");
    coin_event(2, 20);  checkpoint("t3_both");
    coin_event(1, 100); checkpoint("t4_jam");
    coin_event(0, 20);  checkpoint("t4_after_jam");

    // width boundaries
    coin_event(0, 3);  checkpoint("b_w3");
    coin_event(1, 4);  checkpoint("b_w4");
    coin_event(0, 7);  checkpoint("b_w7");
    coin_event(1, 8);  checkpoint("b_w8");
    coin_event(0, 63); checkpoint("b_w63");
    coin_event(1, 64); checkpoint("b_w64");

    // buffer fill with issue held, then drain with exact gaps
    accept_en = 1'b0;
    ae_mode = 1'b0;
    coin_event(0, 20);
    coin_event(1, 20);
    coin_event(0, 20);
    coin_event(1, 20);
    coin_event(0, 20);
    checkpoint("t5_buf");
    base = obs_cyc.size();
    drain(1'b0);
    ae_mode = 1'b1;
    checkpoint("t5_drain");
    for (int i = 1; i < 4; i++) begin
      if (base + i < obs_cyc.size()) check("t5_gap", obs_cyc[base + i] - obs_cyc[base + i - 1], GAP + 1);
      else check("t5_gap_missing", 0, 1);
    end

    // glitching sensor line
    for (int i = 0; i < 10; i++) begin
      coin5_raw = (i % 2 == 0);
      tick();
    end
    coin5_raw = 1'b0;
    repeat (16) tick();
    checkpoint("t6_glitch");

    // reset with coins buffered
    accept_en = 1'b0;
    ae_mode = 1'b0;
    coin_event(0, 20);
    coin_event(1, 20);
    coin_event(0, 20);
    checkpoint("t6_buf");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t6_rst_code", coin_code, 0);
    check("t6_rst_count", coin_count, 0);
    check("t6_rst_full", fifo_full, 0);
    model_buf.delete();
    repeat (2) tick();
    rst = 1'b1;
    accept_en = 1'b1;
    ae_mode = 1'b1;
    repeat (30) tick();
    checkpoint("t6_after_rst");

    // randomized batches
    for (int b = 0; b < 10; b++) begin
      ae_mode = $urandom_range(0, 1);
      accept_en = ae_mode;
      n = $urandom_range(1, 6);
      for (int e = 0; e < n; e++) begin
        kind = ($urandom_range(0, 9) < 2) ? 2 : $urandom_range(0, 1);
        r = $urandom_range(0, 9);
        if (r == 0)      w = $urandom_range(1, DEB - 1);
        else if (r == 1) w = $urandom_range(DEB, MINP - 1);
        else if (r == 2) w = $urandom_range(MAXP, MAXP + 26);
        else             w = $urandom_range(MINP, MAXP - 1);
        coin_event(kind, w);
      end
      checkpoint("rnd_batch");
      if (!ae_mode) begin
        drain(1'b1);
        ae_mode = 1'b1;
        checkpoint("rnd_drain");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
